// File: rtl/calc_pkg.sv
// Shared codes for the calculator front end: modes, validity codes, ASCII constants, parser state.
package calc_pkg;

  localparam int MAX_DIGITS = 3;
  localparam int NUM_W      = 10;

  typedef enum logic [2:0] {
    MODE_NONE = 3'd0,
    MODE_ADD  = 3'd1,
    MODE_SUB  = 3'd2,
    MODE_MUL  = 3'd3,
    MODE_DIV  = 3'd4
  } mode_e;

  localparam logic [1:0] VC_OP1  = 2'b00;
  localparam logic [1:0] VC_OP2  = 2'b01;
  localparam logic [1:0] VC_DONE = 2'b10;
  localparam logic [1:0] VC_ERR  = 2'b11;

  // State encoding doubles as the validCheck code.
  typedef enum logic [1:0] {
    ST_OP1  = 2'b00,
    ST_OP2  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    CL_IGNORE,
    CL_DIGIT,
    CL_OP,
    CL_EVAL,
    CL_CLEAR,
    CL_BS,
    CL_BAD
  } char_class_e;

  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_CLR   = 8'h63;

endpackage

// File: rtl/ascii_classifier.sv
// Combinational decode of one ASCII code into a character class, digit value and operator mode.
module ascii_classifier
  import calc_pkg::*;
(
  input  logic [7:0]  code_i,
  output char_class_e cls_o,
  output logic [3:0]  digit_o,
  output mode_e       op_o
);

  always_comb begin
    cls_o   = CL_BAD;
    digit_o = code_i[3:0];
    op_o    = MODE_NONE;
    if (code_i >= ASC_ZERO && code_i <= ASC_NINE) begin
      cls_o = CL_DIGIT;
    end else begin
      case (code_i)
        8'h2B, 8'h61: begin cls_o = CL_OP; op_o = MODE_ADD; end
        8'h2D, 8'h73: begin cls_o = CL_OP; op_o = MODE_SUB; end
        8'h2A, 8'h6D: begin cls_o = CL_OP; op_o = MODE_MUL; end
        8'h2F, 8'h64: begin cls_o = CL_OP; op_o = MODE_DIV; end
        ASC_EQ, ASC_CR: cls_o = CL_EVAL;
        ASC_CLR:        cls_o = CL_CLEAR;
        ASC_BS:         cls_o = CL_BS;
        ASC_SPACE:      cls_o = CL_IGNORE;
        default:        cls_o = CL_BAD;
      endcase
    end
  end

endmodule

// File: rtl/data_interpreter.sv
// Calculator input parser: assembles decimal operands and operator mode from a strobed ASCII stream.
module data_interpreter
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      ASCII_in,
  output logic [2:0]       modeSelect,
  output logic [1:0]       validCheck,
  output logic [NUM_W-1:0] numOut,
  output logic             printEnable
);

  state_e           state_q, state_d;
  logic [7:0]       prev_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  mode_e            mode_q, mode_d;
  logic             pe_q, pe_d;

  char_class_e cls;
  logic [3:0]  digit;
  mode_e       op;

  ascii_classifier u_cls (
    .code_i  (ASCII_in[7:0]),
    .cls_o   (cls),
    .digit_o (digit),
    .op_o    (op)
  );

  // A new character is a nonzero code that differs from last cycle's code.
  logic accept, err;
  assign accept = (ASCII_in[7:0] != ASC_NUL) && (ASCII_in[7:0] != prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    mode_d  = mode_q;
    pe_d    = 1'b0;
    err     = 1'b0;
    if (accept) begin
      if (ASCII_in[12:8] != 5'd0) begin
        err = 1'b1;
      end else if (cls == CL_CLEAR) begin
        state_d = ST_OP1;
        cnt_d   = 2'd0;
        num_d   = '0;
        mode_d  = MODE_NONE;
      end else if (cls == CL_BAD) begin
        err = 1'b1;
      end else begin
        case (state_q)
          ST_OP1, ST_OP2: begin
            case (cls)
              CL_DIGIT: begin
                if (cnt_q == 2'(MAX_DIGITS)) begin
                  err = 1'b1;
                end else begin
                  // First digit of the second operand replaces the held first operand.
                  num_d = (state_q == ST_OP2 && cnt_q == 2'd0) ? NUM_W'(digit)
                                                                : num_q * NUM_W'(10) + NUM_W'(digit);
                  cnt_d = cnt_q + 2'd1;
                end
              end
              CL_OP: begin
                if (state_q == ST_OP1 && cnt_q != 2'd0) begin
                  mode_d  = op;
                  pe_d    = 1'b1;
                  state_d = ST_OP2;
                  cnt_d   = 2'd0;
                end else begin
                  err = 1'b1;
                end
              end
              CL_EVAL: begin
                if (state_q == ST_OP2 && cnt_q != 2'd0) begin
                  pe_d    = 1'b1;
                  state_d = ST_DONE;
                end else begin
                  err = 1'b1;
                end
              end
              CL_BS: begin
                if (cnt_q != 2'd0) begin
                  num_d = num_q / NUM_W'(10);
                  cnt_d = cnt_q - 2'd1;
                end
              end
              default: ;
            endcase
          end
          ST_DONE: begin
            case (cls)
              CL_DIGIT: begin
                mode_d  = MODE_NONE;
                num_d   = NUM_W'(digit);
                cnt_d   = 2'd1;
                state_d = ST_OP1;
              end
              CL_OP:   err = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
    // Error handling only pulses on entry; ERR is sticky until clear or reset.
    if (err && state_q != ST_ERR) begin
      state_d = ST_ERR;
      num_d   = '0;
      mode_d  = MODE_NONE;
      cnt_d   = 2'd0;
      pe_d    = 1'b1;
    end else if (err) begin
      state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OP1;
      prev_q  <= ASC_NUL;
      cnt_q   <= 2'd0;
      num_q   <= '0;
      mode_q  <= MODE_NONE;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= ASCII_in[7:0];
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      mode_q  <= mode_d;
      pe_q    <= pe_d;
    end
  end

  assign modeSelect  = mode_q;
  assign validCheck  = state_q;
  assign numOut      = num_q;
  assign printEnable = pe_q;

endmodule

// File: tb/tb_data_interpreter.sv
// Directed bench for data_interpreter: one char per negedge, outputs checked after the next posedge.
module tb_data_interpreter;

  logic        clk;
  logic        rst;
  logic [12:0] ASCII_in;
  logic [2:0]  modeSelect;
  logic [1:0]  validCheck;
  logic [9:0]  numOut;
  logic        printEnable;

  int checks = 0;
  int errors = 0;

  data_interpreter dut (
    .clk         (clk),
    .rst         (rst),
    .ASCII_in    (ASCII_in),
    .modeSelect  (modeSelect),
    .validCheck  (validCheck),
    .numOut      (numOut),
    .printEnable (printEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a code for one cycle; on return the posedge has updated the outputs.
  task automatic put(input logic [12:0] c);
    ASCII_in = c;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int num, input int mode, input int vc, input int pe);
    checks++;
    assert (numOut === 10'(num)) else begin
      errors++; $error("FAIL %s numOut got %0d want %0d", tag, numOut, num);
    end
    checks++;
    assert (modeSelect === 3'(mode)) else begin
      errors++; $error("FAIL %s modeSelect got %0d want %0d", tag, modeSelect, mode);
    end
    checks++;
    assert (validCheck === 2'(vc)) else begin
      errors++; $error("FAIL %s validCheck got %0d want %0d", tag, validCheck, vc);
    end
    checks++;
    assert (printEnable === 1'(pe)) else begin
      errors++; $error("FAIL %s printEnable got %0d want %0d", tag, printEnable, pe);
    end
  endtask

  initial begin
    rst = 1'b1;
    ASCII_in = 13'h000;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // "36s"
    put(13'h033); chk("d3", 3, 0, 0, 0);
    put(13'h036); chk("d36", 36, 0, 0, 0);
    put(13'h073); chk("op_s", 36, 2, 1, 1);
    put(13'h000); chk("op_s_pulse_end", 36, 2, 1, 0);
    put(13'h063); chk("clear1", 0, 0, 0, 0);

    // "12+7="
    put(13'h031); put(13'h032); chk("d12", 12, 0, 0, 0);
    put(13'h02B); chk("op_plus", 12, 1, 1, 1);
    put(13'h037); chk("op2_first", 7, 1, 1, 0);
    put(13'h03D); chk("eval", 7, 1, 2, 1);
    put(13'h000); chk("done_hold", 7, 1, 2, 0);
    put(13'h03D); chk("done_eq_ignored", 7, 1, 2, 0);
    put(13'h063); chk("clear2", 0, 0, 0, 0);

    // "9*9=" then '5' starts a new expression
    put(13'h039); put(13'h000); put(13'h02A); chk("op_mul", 9, 3, 1, 1);
    put(13'h039); put(13'h03D); chk("eval_mul", 9, 3, 2, 1);
    put(13'h035); chk("new_expr", 5, 0, 0, 0);
    put(13'h063); chk("clear3", 0, 0, 0, 0);

    // "1234" overflows
    put(13'h031); put(13'h032); put(13'h033); chk("d123", 123, 0, 0, 0);
    put(13'h034); chk("overflow", 0, 0, 3, 1);
    put(13'h000); chk("err_sticky", 0, 0, 3, 0);
    put(13'h037); chk("err_ignores_digit", 0, 0, 3, 0);
    put(13'h063); chk("clear_err", 0, 0, 0, 0);

    // BS with no digits and space are ignored
    put(13'h008); chk("bs_empty", 0, 0, 0, 0);
    put(13'h020); chk("space", 0, 0, 0, 0);

    // "45",BS,"="
    put(13'h034); put(13'h035); chk("d45", 45, 0, 0, 0);
    put(13'h008); chk("bs", 4, 0, 0, 0);
    put(13'h03D); chk("eq_in_op1", 0, 0, 3, 1);
    put(13'h063);

    put(13'h078); chk("bad_x", 0, 0, 3, 1);
    put(13'h063);
    put(13'h02B); chk("op_no_digits", 0, 0, 3, 1);
    put(13'h063);

    // op in OP2 -> error
    put(13'h031); put(13'h02B); put(13'h032); chk("op2_d2", 2, 1, 1, 0);
    put(13'h02D); chk("op_in_op2", 0, 0, 3, 1);
    put(13'h063);

    // held char accepted once
    put(13'h037); put(13'h037); put(13'h037); put(13'h037); chk("held", 7, 0, 0, 0);
    put(13'h000); put(13'h037); chk("regap", 77, 0, 0, 0);
    put(13'h063);

    // nonzero upper bits
    put(13'h131); chk("upper_bits", 0, 0, 3, 1);
    put(13'h063);

    // reset mid-entry wins over a simultaneous char
    put(13'h038); put(13'h033); put(13'h061); chk("pre_rst", 83, 1, 1, 1);
    rst = 1'b1;
    put(13'h035); chk("rst_mid", 0, 0, 0, 0);
    rst = 1'b0;
    put(13'h035); chk("after_rst", 5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
